// File: rtl/psum_acc_pkg.sv
// Shared types, default widths and the requantisation helper for the
// partial-sum accumulator (also intended for the pooling block).
package psum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DRAIN
    } state_e;

    localparam int DEF_IN_W    = 8;
    localparam int DEF_ACC_W   = 32;
    localparam int DEF_OUT_W   = 8;
    localparam int DEF_DEPTH   = 1024;
    localparam int DEF_CH_W    = 6;
    localparam int DEF_SHIFT_W = 5;

    // Operand is the sign-extended accumulator; 64 bits leaves headroom for
    // the rounding add at any ACC_W up to 63.
    function automatic logic signed [63:0] requant(
        input logic signed [63:0] acc,
        input int                 shift,
        input logic               relu,
        input int                 out_w
    );
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        r = acc;
        if (shift > 0) begin
            r = r + (64'sd1 <<< (shift - 1));
        end
        r = r >>> shift;
        if (relu && r[63]) begin
            r = '0;
        end
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (r > max_v) begin
            r = max_v;
        end else if (r < min_v) begin
            r = min_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_accumulator_sram.sv
// Simple dual-port, single-clock SRAM: port A writes, port B reads with
// one cycle of latency (read-during-write returns the old word).
module simple_dual_one_clock #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             ena,
    input  logic             enb,
    input  logic             wea,
    input  logic [AW-1:0]    addra,
    input  logic [AW-1:0]    addrb,
    input  logic [WIDTH-1:0] dia,
    output logic [WIDTH-1:0] dob
);

    logic [WIDTH-1:0] ram [DEPTH];

    always_ff @(posedge clk) begin
        if (ena && wea) begin
            ram[addra] <= dia;
        end
    end

    always_ff @(posedge clk) begin
        if (enb) begin
            dob <= ram[addrb];
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Channel-by-channel partial-sum accumulator: accumulates PE psums in SRAM,
// then drains bias/shift/ReLU/saturated pixels through a 2-entry skid buffer.
module psum_accumulator
    import psum_acc_pkg::*;
#(
    parameter  int IN_W    = DEF_IN_W,
    parameter  int ACC_W   = DEF_ACC_W,
    parameter  int OUT_W   = DEF_OUT_W,
    parameter  int DEPTH   = DEF_DEPTH,
    parameter  int CH_W    = DEF_CH_W,
    parameter  int SHIFT_W = DEF_SHIFT_W,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [AW-1:0]      ofmap_size_i,
    input  logic [CH_W-1:0]    ifmap_ch_i,
    input  logic [ACC_W-1:0]   bias_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic               relu_en_i,
    input  logic [IN_W-1:0]    psum_i,
    input  logic               psum_valid_i,
    output logic               psum_ready_o,
    output logic [OUT_W-1:0]   out_data_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               busy_o,
    output logic               done_o
);

    state_e state_q, state_d;

    logic [AW-1:0]           size_q, pix_q, pix_d, pop_cnt_q, pop_cnt_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d, rd_addr, rd_addr_q, fwd_addr_q;
    logic [CH_W-1:0]         ch_last_q, ch_q, ch_d;
    logic signed [ACC_W-1:0] bias_q, fwd_data_q, sram_dout, rd_data, psum_ext, acc_sum;
    logic [SHIFT_W-1:0]      shift_q;
    logic                    relu_q, fwd_vld_q;
    logic                    rd_vld_q, rd_vld_d, rd_more_q, rd_more_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [OUT_W-1:0]        out_q, out_d, skid_q, skid_d, pp_data;
    logic                    out_valid_q, done_q;
    logic                    cfg_load, accept, pix_wrap, last_accept, pop, push, issue, last_pop;

    simple_dual_one_clock #(
        .WIDTH (ACC_W),
        .DEPTH (DEPTH)
    ) u_sram (
        .clk   (clk),
        .ena   (accept),
        .enb   (1'b1),
        .wea   (accept),
        .addra (pix_q),
        .addrb (rd_addr),
        .dia   (acc_sum),
        .dob   (sram_dout)
    );

    assign cfg_load    = (state_q == IDLE) && start_i;
    assign accept      = (state_q == ACC) && psum_valid_i;
    assign pix_wrap    = (pix_q == size_q);
    assign last_accept = accept && pix_wrap && (ch_q == ch_last_q);
    assign pop         = out_valid_q && out_ready_i;
    assign push        = rd_vld_q;
    assign last_pop    = pop && (pop_cnt_q == size_q);
    // Credit check: never have more reads in flight than free skid slots.
    assign issue       = (state_q == DRAIN) && rd_more_q &&
                         (({1'b0, cnt_q} + {2'b00, rd_vld_q}) < (3'd2 + {2'b00, pop}));

    // The most recent write is the only one the SRAM read may not reflect yet.
    assign psum_ext = {{(ACC_W-IN_W){psum_i[IN_W-1]}}, psum_i};
    assign rd_data  = (fwd_vld_q && (fwd_addr_q == rd_addr_q)) ? fwd_data_q : sram_dout;
    assign acc_sum  = (ch_q == '0) ? (psum_ext + bias_q) : (rd_data + psum_ext);
    assign pp_data  = OUT_W'(requant({{(64-ACC_W){rd_data[ACC_W-1]}}, rd_data},
                                     int'(shift_q), relu_q, OUT_W));

    assign rd_addr  = (state_q == DRAIN) ? rd_ptr_q : pix_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i)     state_d = ACC;
            ACC:     if (last_accept) state_d = DRAIN;
            DRAIN:   if (last_pop)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pix_d     = pix_q;
        ch_d      = ch_q;
        pop_cnt_d = pop_cnt_q;
        rd_vld_d  = 1'b0;
        rd_more_d = rd_more_q;
        rd_ptr_d  = rd_ptr_q;
        if (cfg_load) begin
            pix_d     = '0;
            ch_d      = '0;
            pop_cnt_d = '0;
        end else if (accept) begin
            if (pix_wrap) begin
                pix_d = '0;
                ch_d  = ch_q + 1'b1;
            end else begin
                pix_d = pix_q + 1'b1;
            end
        end
        if (pop) begin
            pop_cnt_d = pop_cnt_q + 1'b1;
        end
        // The final accept wraps pix_d to 0, so pixel 0's read goes out on that edge.
        if (last_accept) begin
            rd_vld_d  = 1'b1;
            rd_ptr_d  = AW'(1);
            rd_more_d = (size_q != '0);
        end else if (issue) begin
            rd_vld_d  = 1'b1;
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_more_d = (rd_ptr_q != size_q);
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out_q;
        skid_d = skid_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) out_d  = pp_data;
                else               skid_d = pp_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                if (cnt_q == 2'd2) out_d = skid_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    out_d  = skid_q;
                    skid_d = pp_data;
                end else begin
                    out_d  = pp_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            size_q      <= '0;
            ch_last_q   <= '0;
            bias_q      <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            pix_q       <= '0;
            ch_q        <= '0;
            pop_cnt_q   <= '0;
            rd_ptr_q    <= '0;
            rd_addr_q   <= '0;
            rd_vld_q    <= 1'b0;
            rd_more_q   <= 1'b0;
            fwd_vld_q   <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            if (cfg_load) begin
                size_q    <= ofmap_size_i;
                ch_last_q <= ifmap_ch_i;
                bias_q    <= bias_i;
                shift_q   <= shift_i;
                relu_q    <= relu_en_i;
                fwd_vld_q <= 1'b0;
            end else if (accept) begin
                fwd_vld_q  <= 1'b1;
                fwd_addr_q <= pix_q;
                fwd_data_q <= acc_sum;
            end
            pix_q       <= pix_d;
            ch_q        <= ch_d;
            pop_cnt_q   <= pop_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_addr_q   <= rd_addr;
            rd_vld_q    <= rd_vld_d;
            rd_more_q   <= rd_more_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= (cnt_d != 2'd0);
            done_q      <= last_pop;
        end
    end

    assign psum_ready_o = (state_q == ACC);
    assign busy_o       = (state_q != IDLE);
    assign out_data_o   = out_q;
    assign out_valid_o  = out_valid_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: expected pixels are queued when a
// job is driven and compared in order as the output port handshakes.
module tb_psum_accumulator;

    localparam int IN_W    = 8;
    localparam int ACC_W   = 32;
    localparam int OUT_W   = 8;
    localparam int DEPTH   = 64;
    localparam int AW      = $clog2(DEPTH);
    localparam int CH_W    = 6;
    localparam int SHIFT_W = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [AW-1:0]      ofmap_size = '0;
    logic [CH_W-1:0]    ifmap_ch = '0;
    logic [ACC_W-1:0]   bias = '0;
    logic [SHIFT_W-1:0] shift = '0;
    logic               relu_en = 1'b0;
    logic [IN_W-1:0]    psum = '0;
    logic               psum_valid = 1'b0;
    logic               psum_ready;
    logic [OUT_W-1:0]   out_data;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               busy;
    logic               done;

    int n_tests = 0;
    int n_fail  = 0;
    int ready_pct = 100;
    int psq[$];
    int exp_q[$];

    logic   stall = 1'b0;
    logic   done_exp = 1'b0;
    longint held = 0;

    psum_accumulator #(
        .IN_W    (IN_W),
        .ACC_W   (ACC_W),
        .OUT_W   (OUT_W),
        .DEPTH   (DEPTH),
        .CH_W    (CH_W),
        .SHIFT_W (SHIFT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .ofmap_size_i (ofmap_size),
        .ifmap_ch_i   (ifmap_ch),
        .bias_i       (bias),
        .shift_i      (shift),
        .relu_en_i    (relu_en),
        .psum_i       (psum),
        .psum_valid_i (psum_valid),
        .psum_ready_o (psum_ready),
        .out_data_o   (out_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int ref_out(input int acc, input int sh, input bit relu);
        longint r;
        r = acc;
        if (sh > 0) r = r + (longint'(1) << (sh - 1));
        r = r >>> sh;
        if (relu && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(99) < ready_pct);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall    = 1'b0;
            done_exp = 1'b0;
        end else begin
            if (done_exp) begin
                check_eq("done_pulse", done, 1);
                check_eq("idle_at_done", busy, 0);
                done_exp = 1'b0;
            end else if (done) begin
                check_eq("done_spurious", done, 0);
            end
            if (stall) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_data", $signed(out_data), held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_output", out_valid, 0);
                end else begin
                    check_eq("out_data", $signed(out_data), exp_q.pop_front());
                    if (exp_q.size() == 0) done_exp = 1'b1;
                end
                stall = 1'b0;
            end else if (out_valid) begin
                stall = 1'b1;
                held  = $signed(out_data);
            end else begin
                stall = 1'b0;
            end
        end
    end

    task automatic run_job(input int size, input int chl, input int bv, input int sh,
                           input bit relu, input int rdy_pct, input int gap_pct);
        int acc[];
        int cycles;
        acc = new[size + 1];
        for (int p = 0; p <= size; p++) acc[p] = bv;
        for (int i = 0; i < psq.size(); i++) acc[i % (size + 1)] += psq[i];
        for (int p = 0; p <= size; p++) exp_q.push_back(ref_out(acc[p], sh, relu));
        ready_pct = rdy_pct;

        @(posedge clk); #1;
        ofmap_size = AW'(size);
        ifmap_ch   = CH_W'(chl);
        bias       = ACC_W'(bv);
        shift      = SHIFT_W'(sh);
        relu_en    = relu;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);

        for (int i = 0; i < psq.size(); i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                psum_valid = 1'b0;
                @(posedge clk); #1;
            end
            psum       = IN_W'(psq[i]);
            psum_valid = 1'b1;
            if (i == 0) check_eq("psum_ready", psum_ready, 1);
            @(posedge clk); #1;
        end
        psum_valid = 1'b0;

        check_eq("lat_no_valid_yet", out_valid, 0);
        @(posedge clk); #1;
        check_eq("lat_first_valid", out_valid, 1);
        cycles = 1;
        while (!done && cycles < 3000) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!done) check_eq("timeout_done", done, 1);
        else if (rdy_pct == 100) check_eq("drain_cycles", cycles, size + 2);
        check_eq("sb_empty", exp_q.size(), 0);
        psq.delete();
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ready", psum_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        psq = '{1, 2, 3, 4, 10, 20, 30, 40};
        run_job(3, 1, 0, 0, 1'b0, 100, 0);

        psq = '{127, 127, 127, 127};
        run_job(0, 3, 0, 0, 1'b0, 100, 0);
        psq = '{-128, -128, -128, -128};
        run_job(0, 3, 0, 0, 1'b0, 100, 0);

        psq = '{5, 30};
        run_job(1, 0, -20, 0, 1'b1, 100, 0);
        psq = '{5, 30};
        run_job(1, 0, -20, 0, 1'b0, 100, 0);

        psq = '{0};
        run_job(0, 0, 100, 3, 1'b0, 100, 0);
        psq = '{0};
        run_job(0, 0, -100, 3, 1'b0, 100, 0);

        for (int i = 0; i < 24; i++) psq.push_back(int'($urandom_range(255)) - 128);
        run_job(7, 2, int'($urandom_range(200)) - 100, 2, 1'b0, 30, 20);

        // Abort a job mid-accumulation; nothing from it may ever appear.
        ready_pct  = 100;
        ofmap_size = AW'(3);
        ifmap_ch   = CH_W'(2);
        bias       = ACC_W'(55);
        shift      = '0;
        relu_en    = 1'b0;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            psum       = IN_W'(90 + i);
            psum_valid = 1'b1;
            @(posedge clk); #1;
        end
        rst_n      = 1'b0;
        psum_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_ready", psum_ready, 0);
        check_eq("midrst_valid", out_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check_eq("postrst_quiet", out_valid, 0);
        end

        psq = '{3, 4};
        run_job(1, 0, 0, 0, 1'b0, 100, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Parametrised partial-sum accumulator for the conv datapath, succeeding the fixed 8-bit/32-bit accumulator. It receives a stream of signed partial sums from the PE array, one per output pixel per input channel, and accumulates them channel by channel in an on-chip SRAM. It then post-processes each pixel with bias, rounding right shift, optional ReLU and saturation, and drains the results through a ready/valid output port with backpressure.

## Interface
Parameters:
- IN_W, 8, partial-sum width (signed)
- ACC_W, 32, accumulator/SRAM word width (signed)
- OUT_W, 8, output width (signed, saturated)
- DEPTH, 1024, max output pixels; AW = $clog2(DEPTH)
- CH_W, 6, channel-count field width
- SHIFT_W, 5, requant shift field width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start_i  in  1  one-cycle pulse; latches config; honoured only in IDLE
- ofmap_size_i  in  AW  last pixel index (pixels = value+1)
- ifmap_ch_i  in  CH_W  last channel index (channels = value+1)
- bias_i  in  ACC_W  signed bias, added once per pixel
- shift_i  in  SHIFT_W  arithmetic right-shift amount
- relu_en_i  in  1  clamp negatives to 0
- psum_i  in  IN_W  signed partial sum
- psum_valid_i  in  1  psum_i valid
- psum_ready_o  out  1  block accepts psum
- out_data_o  out  OUT_W  result pixel
- out_valid_o  out  1  out_data_o valid
- out_ready_i  in  1  downstream accepts
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse after last output handshake

## Operation
- FSM: IDLE -> ACC on start_i. Config registers are latched at start and ignored afterwards.
- ACC -> DRAIN when the psum for pixel ofmap_size, channel ifmap_ch, is accepted.
- DRAIN -> IDLE after the handshake on pixel ofmap_size, with a done_o pulse.
- ACC: psum_ready_o=1. On accept, pix_cnt counts 0..ofmap_size and wraps to 0 while ch_cnt increments.
- Each accept writes to SRAM[pix_cnt]:
  - ch_cnt==0: write sext(psum)+bias.
  - otherwise: write SRAM[pix_cnt]+sext(psum).
- Read is prefetched one cycle ahead (SRAM read latency 1).
- Read-after-write hazard (e.g. ofmap_size=0, or back-to-back accesses to the same address): a forwarding register supplies the in-flight sum, so no stall is inserted. psum_ready_o stays 1 throughout ACC.
- Accumulation wraps modulo 2^ACC_W with no overflow detection; sizing is the user's responsibility.
- DRAIN post-processing, per pixel:
  - r = (acc + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, arithmetic, computed in ACC_W+1 bits.
  - If relu_en and r<0, r=0.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- DRAIN order is pixel 0..ofmap_size. Each pixel is emitted exactly once, with no drops or duplicates under any out_ready_i pattern.
- psum_valid_i is ignored outside ACC. start_i is ignored outside IDLE.

## Timing
- Reset values: state=IDLE, counters 0, psum_ready_o=0, out_valid_o=0, out_data_o=0, busy_o=0, done_o=0. SRAM contents are not cleared; no clear is needed because ch 0 overwrites every entry.
- Reset mid-operation returns to IDLE on the next edge. No partial output is emitted afterwards.
- ACC throughput: 1 psum/cycle.
- First out_valid_o: 2 cycles after the last psum accept (SRAM read, then output register).
- out_data_o and out_valid_o are registered.
- Output handshake rules:
  - Once out_valid_o is asserted, out_data_o holds stable until out_valid_o && out_ready_i.
  - With out_ready_i held at 1: one result per cycle, no bubbles.
  - A 2-entry skid buffer absorbs the SRAM read latency when out_ready_i drops.
- done_o: the cycle after the final output handshake; the FSM is in IDLE in that same cycle.
- Minimum job: ofmap_size=0, ifmap_ch=0 → 1 psum, 1 output.

## Structure
- Package psum_acc_pkg:
  - FSM state enum {IDLE, ACC, DRAIN}.
  - Default parameter localparams.
  - A function for shift/round/relu/saturate, shared with the future pooling block.
- Sub-module: the existing simple_dual_one_clock SRAM, instantiated with DEPTH×ACC_W.
  - Port A: write (pix_cnt, sum).
  - Port B: read (rd_ptr).
- Top-level RTL holds the FSM, counters, forwarding path, post-processing and skid buffer.

## Test plan
- ofmap_size=3, ifmap_ch=1, bias=0, shift=0; ch0 psums 1,2,3,4; ch1 psums 10,20,30,40 → outputs 11,22,33,44, then done_o.
- ofmap_size=0, ifmap_ch=3; psums 127 ×4 back-to-back → 127 (forwarded sum 508 saturated). Same with -128 ×4 → -128.
- bias=-20, relu_en=1, single channel, psums 5,30 → 0,10. Same with relu_en=0 → -15,10.
- shift=3, bias=100, psum 0 → (100+4)>>>3 = 13. bias=-100 → -12.
- ofmap_size=7, random out_ready_i at 30% duty → 8 outputs in order, each once, data stable while stalled.
- Reset asserted mid-ACC, then a new job with ofmap_size=1, ifmap_ch=0, psums 3,4 → outputs exactly 3,4, with no stale data.
